// File: rtl/cpu_defs_pkg.sv
// Shared definitions for the accumulator processor: opcodes, sequencer states
// and the bundle of control strobes the sequencer drives onto the system bus.
package cpu_defs_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_LOAD  = 3'b000,
        OP_STORE = 3'b001,
        OP_ADD   = 3'b010,
        OP_SUB   = 3'b011,
        OP_BNE   = 3'b100,
        OP_BRA   = 3'b101,
        OP_HALT  = 3'b110,
        OP_NOP   = 3'b111
    } opcode_t;

    typedef enum logic [2:0] {
        FETCH0 = 3'd0,
        FETCH1 = 3'd1,
        FETCH2 = 3'd2,
        EXEC0  = 3'd3,
        EXEC1  = 3'd4,
        EXEC2  = 3'd5,
        HALT   = 3'd6
    } state_t;

    typedef struct packed {
        logic acc_bus;
        logic load_acc;
        logic alu_acc;
        logic alu_add;
        logic alu_sub;
        logic pc_bus;
        logic load_pc;
        logic inc_pc;
        logic addr_bus;
        logic load_ir;
        logic load_mar;
        logic mdr_bus;
        logic load_mdr;
        logic cs;
        logic r_nw;
        logic halted;
    } ctrl_t;

    // Instructions that fetch or store a memory operand through MAR/MDR.
    function automatic logic uses_operand(input opcode_t op);
        return (op == OP_LOAD) || (op == OP_STORE) ||
               (op == OP_ADD)  || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/sequencer.sv
// Fetch/decode/execute control unit for the accumulator processor. Outputs are
// decoded from the state (plus op/z_flag in EXEC states) and forced low in reset.
module sequencer #(
    parameter int OP_W = cpu_defs_pkg::OP_W
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [OP_W-1:0] op,
    input  logic            z_flag,
    output logic            ACC_bus,
    output logic            load_ACC,
    output logic            ALU_ACC,
    output logic            ALU_add,
    output logic            ALU_sub,
    output logic            PC_bus,
    output logic            load_PC,
    output logic            INC_PC,
    output logic            Addr_bus,
    output logic            load_IR,
    output logic            load_MAR,
    output logic            MDR_bus,
    output logic            load_MDR,
    output logic            CS,
    output logic            R_NW,
    output logic            halted
);
    import cpu_defs_pkg::*;

    state_t  state_q;
    state_t  state_d;
    ctrl_t   ctrl;
    opcode_t op_e;

    assign op_e = opcode_t'(op);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= FETCH0;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        ctrl    = '0;
        state_d = FETCH0;
        unique case (state_q)
            FETCH0: begin
                ctrl.pc_bus   = 1'b1;
                ctrl.load_mar = 1'b1;
                ctrl.load_pc  = 1'b1;
                ctrl.inc_pc   = 1'b1;
                state_d       = FETCH1;
            end
            FETCH1: begin
                ctrl.cs       = 1'b1;
                ctrl.r_nw     = 1'b1;
                ctrl.load_mdr = 1'b1;
                state_d       = FETCH2;
            end
            FETCH2: begin
                ctrl.mdr_bus = 1'b1;
                ctrl.load_ir = 1'b1;
                state_d      = EXEC0;
            end
            EXEC0: begin
                if (uses_operand(op_e)) begin
                    ctrl.addr_bus = 1'b1;
                    ctrl.load_mar = 1'b1;
                    state_d       = EXEC1;
                end else if ((op_e == OP_BRA) || ((op_e == OP_BNE) && !z_flag)) begin
                    ctrl.addr_bus = 1'b1;
                    ctrl.load_pc  = 1'b1;
                    state_d       = FETCH0;
                end else if (op_e == OP_HALT) begin
                    state_d = HALT;
                end else begin
                    state_d = FETCH0;
                end
            end
            EXEC1: begin
                if (op_e == OP_STORE) begin
                    ctrl.acc_bus  = 1'b1;
                    ctrl.load_mdr = 1'b1;
                end else begin
                    ctrl.cs       = 1'b1;
                    ctrl.r_nw     = 1'b1;
                    ctrl.load_mdr = 1'b1;
                end
                state_d = EXEC2;
            end
            EXEC2: begin
                // STORE writes memory: CS with R_NW left low.
                if (op_e == OP_STORE) begin
                    ctrl.cs = 1'b1;
                end else begin
                    ctrl.mdr_bus  = 1'b1;
                    ctrl.load_acc = 1'b1;
                    ctrl.alu_acc  = (op_e == OP_ADD) || (op_e == OP_SUB);
                    ctrl.alu_add  = (op_e == OP_ADD);
                    ctrl.alu_sub  = (op_e == OP_SUB);
                end
                state_d = FETCH0;
            end
            HALT: begin
                ctrl.halted = 1'b1;
                state_d     = HALT;
            end
            default: begin
                ctrl    = '0;
                state_d = FETCH0;
            end
        endcase
        if (reset) begin
            ctrl = '0;
        end
    end

    assign ACC_bus  = ctrl.acc_bus;
    assign load_ACC = ctrl.load_acc;
    assign ALU_ACC  = ctrl.alu_acc;
    assign ALU_add  = ctrl.alu_add;
    assign ALU_sub  = ctrl.alu_sub;
    assign PC_bus   = ctrl.pc_bus;
    assign load_PC  = ctrl.load_pc;
    assign INC_PC   = ctrl.inc_pc;
    assign Addr_bus = ctrl.addr_bus;
    assign load_IR  = ctrl.load_ir;
    assign load_MAR = ctrl.load_mar;
    assign MDR_bus  = ctrl.mdr_bus;
    assign load_MDR = ctrl.load_mdr;
    assign CS       = ctrl.cs;
    assign R_NW     = ctrl.r_nw;
    assign halted   = ctrl.halted;

endmodule

// File: tb/tb_sequencer.sv
// Bench for the sequencer: per-instruction expected strobe vectors are queued
// and compared cycle by cycle, with bus invariants watched on every cycle.
module tb_sequencer;

    localparam logic [15:0] M_ACC_BUS = 16'h8000;
    localparam logic [15:0] M_LD_ACC  = 16'h4000;
    localparam logic [15:0] M_ALU_ACC = 16'h2000;
    localparam logic [15:0] M_ADD     = 16'h1000;
    localparam logic [15:0] M_SUB     = 16'h0800;
    localparam logic [15:0] M_PC_BUS  = 16'h0400;
    localparam logic [15:0] M_LD_PC   = 16'h0200;
    localparam logic [15:0] M_INC_PC  = 16'h0100;
    localparam logic [15:0] M_ADDR    = 16'h0080;
    localparam logic [15:0] M_LD_IR   = 16'h0040;
    localparam logic [15:0] M_LD_MAR  = 16'h0020;
    localparam logic [15:0] M_MDR_BUS = 16'h0010;
    localparam logic [15:0] M_LD_MDR  = 16'h0008;
    localparam logic [15:0] M_CS      = 16'h0004;
    localparam logic [15:0] M_RNW     = 16'h0002;
    localparam logic [15:0] M_HALTED  = 16'h0001;

    localparam logic [15:0] V_F0 = M_PC_BUS | M_LD_MAR | M_LD_PC | M_INC_PC;
    localparam logic [15:0] V_F1 = M_CS | M_RNW | M_LD_MDR;
    localparam logic [15:0] V_F2 = M_MDR_BUS | M_LD_IR;

    logic       clock = 1'b0;
    logic       reset;
    logic [2:0] op;
    logic       z_flag;
    logic ACC_bus, load_ACC, ALU_ACC, ALU_add, ALU_sub, PC_bus, load_PC, INC_PC;
    logic Addr_bus, load_IR, load_MAR, MDR_bus, load_MDR, CS, R_NW, halted;
    logic [15:0] obs;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_f0 = -1;
    logic [15:0] expq[$];

    always #5 clock = ~clock;

    sequencer #(.OP_W(3)) dut (
        .clock(clock), .reset(reset), .op(op), .z_flag(z_flag),
        .ACC_bus(ACC_bus), .load_ACC(load_ACC), .ALU_ACC(ALU_ACC),
        .ALU_add(ALU_add), .ALU_sub(ALU_sub), .PC_bus(PC_bus),
        .load_PC(load_PC), .INC_PC(INC_PC), .Addr_bus(Addr_bus),
        .load_IR(load_IR), .load_MAR(load_MAR), .MDR_bus(MDR_bus),
        .load_MDR(load_MDR), .CS(CS), .R_NW(R_NW), .halted(halted)
    );

    assign obs = {ACC_bus, load_ACC, ALU_ACC, ALU_add, ALU_sub, PC_bus, load_PC, INC_PC,
                  Addr_bus, load_IR, load_MAR, MDR_bus, load_MDR, CS, R_NW, halted};

    // Invariants and instruction length, checked on every non-reset cycle.
    always @(negedge clock) begin
        cyc++;
        if (reset) begin
            last_f0 = -1;
        end else begin
            checks++;
            if ((int'(ACC_bus) + int'(PC_bus) + int'(Addr_bus) + int'(MDR_bus)) > 1) begin
                errors++;
                $display("FAIL bus_exclusive cyc%0d: got %h required at most one bus enable", cyc, obs);
            end
            if (ALU_add && ALU_sub) begin
                errors++;
                $display("FAIL alu_select cyc%0d: got %h required not both add and sub", cyc, obs);
            end
            if ((ALU_add || ALU_sub) && !(load_ACC && ALU_ACC)) begin
                errors++;
                $display("FAIL alu_with_load cyc%0d: got %h required load_ACC and ALU_ACC", cyc, obs);
            end
            if (R_NW && !CS) begin
                errors++;
                $display("FAIL rnw_cs cyc%0d: got %h required R_NW only with CS", cyc, obs);
            end
            if (obs === V_F0) begin
                if (last_f0 >= 0) begin
                    checks++;
                    if ((cyc - last_f0) != 4 && (cyc - last_f0) != 6) begin
                        errors++;
                        $display("FAIL instr_len cyc%0d: got %0d cycles required 4 or 6", cyc, cyc - last_f0);
                    end
                end
                last_f0 = cyc;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // Drives op/z for one instruction (called at the start of its FETCH0) and
    // queues the strobe vector each of its cycles must show.
    task automatic push_instr(input logic [2:0] o, input logic z);
        op     = o;
        z_flag = z;
        expq.push_back(V_F0);
        expq.push_back(V_F1);
        expq.push_back(V_F2);
        case (o)
            3'b000: begin
                expq.push_back(M_ADDR | M_LD_MAR);
                expq.push_back(M_CS | M_RNW | M_LD_MDR);
                expq.push_back(M_MDR_BUS | M_LD_ACC);
            end
            3'b001: begin
                expq.push_back(M_ADDR | M_LD_MAR);
                expq.push_back(M_ACC_BUS | M_LD_MDR);
                expq.push_back(M_CS);
            end
            3'b010: begin
                expq.push_back(M_ADDR | M_LD_MAR);
                expq.push_back(M_CS | M_RNW | M_LD_MDR);
                expq.push_back(M_MDR_BUS | M_LD_ACC | M_ALU_ACC | M_ADD);
            end
            3'b011: begin
                expq.push_back(M_ADDR | M_LD_MAR);
                expq.push_back(M_CS | M_RNW | M_LD_MDR);
                expq.push_back(M_MDR_BUS | M_LD_ACC | M_ALU_ACC | M_SUB);
            end
            3'b100:  expq.push_back(z ? 16'h0000 : (M_ADDR | M_LD_PC));
            3'b101:  expq.push_back(M_ADDR | M_LD_PC);
            default: expq.push_back(16'h0000);
        endcase
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        op     = 3'b111;
        z_flag = 1'b0;
        repeat (2) begin
            @(negedge clock);
            checks++;
            if (obs !== 16'h0000) begin
                errors++;
                $display("FAIL reset_outputs: got %h required 0000", obs);
            end
            @(posedge clock); #1;
        end
        reset = 1'b0;
        push_instr(3'b111, 1'b0);
        while (expq.size() > 0) begin
            logic [15:0] e;
            e = expq.pop_front();
            @(negedge clock);
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL reset_then_nop: got %h required %h", obs, e);
            end
            @(posedge clock); #1;
        end
    endtask

    task automatic test_add();
        push_instr(3'b010, 1'b0);
        push_instr(3'b010, 1'b0);
        for (int i = 0; i < 7; i++) begin
            logic [15:0] e;
            e = expq.pop_front();
            @(negedge clock);
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL add_seq c%0d: got %h required %h", i + 1, obs, e);
            end
            @(posedge clock); #1;
        end
        expq.delete();
        // Cycle 7 was the next FETCH0; finish that ADD so the state is aligned.
        push_instr(3'b010, 1'b0);
        void'(expq.pop_front());
        while (expq.size() > 0) begin
            logic [15:0] e;
            e = expq.pop_front();
            @(negedge clock);
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL add_tail: got %h required %h", obs, e);
            end
            @(posedge clock); #1;
        end
    endtask

    task automatic test_store();
        push_instr(3'b001, 1'b1);
        while (expq.size() > 0) begin
            logic [15:0] e;
            e = expq.pop_front();
            @(negedge clock);
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL store_seq: got %h required %h", obs, e);
            end
            @(posedge clock); #1;
        end
    endtask

    task automatic test_bne();
        for (int k = 0; k < 2; k++) begin
            push_instr(3'b100, k[0]);
            while (expq.size() > 0) begin
                logic [15:0] e;
                e = expq.pop_front();
                @(negedge clock);
                checks++;
                if (obs !== e) begin
                    errors++;
                    $display("FAIL bne_z%0d: got %h required %h", k, obs, e);
                end
                @(posedge clock); #1;
            end
        end
    endtask

    task automatic test_reset_mid();
        push_instr(3'b010, 1'b0);
        for (int i = 0; i < 4; i++) begin
            logic [15:0] e;
            e = expq.pop_front();
            @(negedge clock);
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL mid_pre c%0d: got %h required %h", i + 1, obs, e);
            end
            @(posedge clock); #1;
        end
        expq.delete();
        reset = 1'b1;
        repeat (2) begin
            @(negedge clock);
            checks++;
            if (obs !== 16'h0000) begin
                errors++;
                $display("FAIL mid_reset: got %h required 0000", obs);
            end
            @(posedge clock); #1;
        end
        reset = 1'b0;
        push_instr(3'b000, 1'b0);
        while (expq.size() > 0) begin
            logic [15:0] e;
            e = expq.pop_front();
            @(negedge clock);
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL mid_after: got %h required %h", obs, e);
            end
            @(posedge clock); #1;
        end
    endtask

    task automatic test_halt();
        push_instr(3'b110, 1'b0);
        repeat (22) expq.push_back(M_HALTED);
        while (expq.size() > 0) begin
            logic [15:0] e;
            e = expq.pop_front();
            @(negedge clock);
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL halt_seq: got %h required %h", obs, e);
            end
            @(posedge clock); #1;
        end
        reset = 1'b1;
        @(negedge clock);
        checks++;
        if (obs !== 16'h0000) begin
            errors++;
            $display("FAIL halt_reset: got %h required 0000", obs);
        end
        @(posedge clock); #1;
        reset = 1'b0;
        push_instr(3'b101, 1'b1);
        while (expq.size() > 0) begin
            logic [15:0] e;
            e = expq.pop_front();
            @(negedge clock);
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL halt_exit: got %h required %h", obs, e);
            end
            @(posedge clock); #1;
        end
    endtask

    task automatic test_random();
        int n = 0;
        while (n < 10000) begin
            logic [2:0] o;
            o = 3'($urandom_range(0, 6));
            if (o == 3'b110) o = 3'b111;
            push_instr(o, 1'($urandom_range(0, 1)));
            while (expq.size() > 0) begin
                logic [15:0] e;
                e = expq.pop_front();
                @(negedge clock);
                checks++;
                if (obs !== e) begin
                    errors++;
                    $display("FAIL random op%0d z%0b: got %h required %h", o, z_flag, obs, e);
                end
                @(posedge clock); #1;
                n++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_store();
        test_bne();
        test_reset_mid();
        test_halt();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
